// File: rtl/nurn_cfg_sequencer.sv
// rtl/nurn_cfg_sequencer.sv - per-time-step scan of neuron config ports A/B and axon port C
// Walks neurons (A/B reads), then optionally each axon (C read), with valid/ready handoff downstream.
module nurn_cfg_sequencer #(
  parameter int NUM_NURNS          = 256,
  parameter int NUM_AXONS          = 256,
  parameter int NURN_CNT_BIT_WIDTH = 8,
  parameter int AXON_CNT_BIT_WIDTH = 8
) (
  input  logic                                         clk_i,
  input  logic                                         rst_i,
  input  logic                                         start_i,
  input  logic                                         axon_scan_en_i,
  output logic                                         busy_o,
  output logic                                         done_o,
  output logic [NURN_CNT_BIT_WIDTH-1:0]                Addr_Config_A_o,
  output logic                                         rdEn_Config_A_o,
  output logic [NURN_CNT_BIT_WIDTH-1:0]                Addr_Config_B_o,
  output logic                                         rdEn_Config_B_o,
  output logic [NURN_CNT_BIT_WIDTH+AXON_CNT_BIT_WIDTH-1:0] Addr_Config_C_o,
  output logic                                         rdEn_Config_C_o,
  input  logic                                         axonLrnMode_i,
  output logic [NURN_CNT_BIT_WIDTH-1:0]                nurn_idx_o,
  output logic                                         nurn_vld_o,
  input  logic                                         nurn_rdy_i,
  output logic [AXON_CNT_BIT_WIDTH-1:0]                axon_idx_o,
  output logic                                         axon_lrn_o,
  output logic                                         axon_vld_o,
  input  logic                                         axon_rdy_i
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NRD,
    S_NOUT,
    S_ARD,
    S_AOUT,
    S_NEXT,
    S_DONE
  } state_t;

  localparam logic [NURN_CNT_BIT_WIDTH-1:0] NURN_LAST = NURN_CNT_BIT_WIDTH'(NUM_NURNS - 1);
  localparam logic [AXON_CNT_BIT_WIDTH-1:0] AXON_LAST = AXON_CNT_BIT_WIDTH'(NUM_AXONS - 1);
  localparam logic [NURN_CNT_BIT_WIDTH-1:0] NURN_ONE  = NURN_CNT_BIT_WIDTH'(1);
  localparam logic [AXON_CNT_BIT_WIDTH-1:0] AXON_ONE  = AXON_CNT_BIT_WIDTH'(1);

  state_t                          state_q, state_d;
  logic [NURN_CNT_BIT_WIDTH-1:0]   nurn_cnt_q, nurn_cnt_d;
  logic [AXON_CNT_BIT_WIDTH-1:0]   axon_cnt_q, axon_cnt_d;
  logic                            scan_en_q, scan_en_d;
  logic                            lrn_q;
  logic                            aout_first_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      nurn_cnt_q   <= '0;
      axon_cnt_q   <= '0;
      scan_en_q    <= 1'b0;
      lrn_q        <= 1'b0;
      aout_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      nurn_cnt_q   <= nurn_cnt_d;
      axon_cnt_q   <= axon_cnt_d;
      scan_en_q    <= scan_en_d;
      aout_first_q <= (state_q == S_ARD);
      if (aout_first_q) begin
        lrn_q <= axonLrnMode_i;
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    nurn_cnt_d      = nurn_cnt_q;
    axon_cnt_d      = axon_cnt_q;
    scan_en_d       = scan_en_q;
    busy_o          = 1'b0;
    done_o          = 1'b0;
    Addr_Config_A_o = '0;
    rdEn_Config_A_o = 1'b0;
    Addr_Config_B_o = '0;
    rdEn_Config_B_o = 1'b0;
    Addr_Config_C_o = '0;
    rdEn_Config_C_o = 1'b0;
    nurn_vld_o      = 1'b0;
    axon_vld_o      = 1'b0;
    nurn_idx_o      = nurn_cnt_q;
    axon_idx_o      = axon_cnt_q;
    // Memory output is live in the first AOUT cycle; the local copy covers the rest of the stall.
    axon_lrn_o      = aout_first_q ? axonLrnMode_i : lrn_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          scan_en_d  = axon_scan_en_i;
          nurn_cnt_d = '0;
          axon_cnt_d = '0;
          state_d    = S_NRD;
        end
      end
      S_NRD: begin
        busy_o          = 1'b1;
        rdEn_Config_A_o = 1'b1;
        rdEn_Config_B_o = 1'b1;
        Addr_Config_A_o = nurn_cnt_q;
        Addr_Config_B_o = nurn_cnt_q;
        state_d         = S_NOUT;
      end
      S_NOUT: begin
        busy_o     = 1'b1;
        nurn_vld_o = 1'b1;
        if (nurn_rdy_i) begin
          state_d = scan_en_q ? S_ARD : S_NEXT;
        end
      end
      S_ARD: begin
        busy_o          = 1'b1;
        rdEn_Config_C_o = 1'b1;
        Addr_Config_C_o = {nurn_cnt_q, axon_cnt_q};
        state_d         = S_AOUT;
      end
      S_AOUT: begin
        busy_o     = 1'b1;
        axon_vld_o = 1'b1;
        if (axon_rdy_i) begin
          if (axon_cnt_q == AXON_LAST) begin
            axon_cnt_d = '0;
            state_d    = S_NEXT;
          end else begin
            axon_cnt_d = axon_cnt_q + AXON_ONE;
            state_d    = S_ARD;
          end
        end
      end
      S_NEXT: begin
        busy_o = 1'b1;
        if (nurn_cnt_q == NURN_LAST) begin
          state_d = S_DONE;
        end else begin
          nurn_cnt_d = nurn_cnt_q + NURN_ONE;
          state_d    = S_NRD;
        end
      end
      S_DONE: begin
        done_o  = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_nurn_cfg_sequencer.sv
// tb/tb_nurn_cfg_sequencer.sv - scoreboard bench for nurn_cfg_sequencer
// Stimulus pushes the expected scan into queues; a negedge monitor pops and compares.
module tb_nurn_cfg_sequencer;
  localparam int NN = 4;
  localparam int NA = 3;
  localparam int NW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_i, start_i, axon_scan_en_i;
  logic          busy_o, done_o;
  logic [NW-1:0] addr_a, addr_b;
  logic          rd_a, rd_b;
  logic [NW+AW-1:0] addr_c;
  logic          rd_c;
  logic          lrn_in = 1'b0;
  logic [NW-1:0] nurn_idx;
  logic          nurn_vld, nurn_rdy;
  logic [AW-1:0] axon_idx;
  logic          axon_lrn, axon_vld, axon_rdy;

  always #5 clk = ~clk;

  nurn_cfg_sequencer #(
    .NUM_NURNS(NN), .NUM_AXONS(NA), .NURN_CNT_BIT_WIDTH(NW), .AXON_CNT_BIT_WIDTH(AW)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .axon_scan_en_i(axon_scan_en_i),
    .busy_o(busy_o), .done_o(done_o),
    .Addr_Config_A_o(addr_a), .rdEn_Config_A_o(rd_a),
    .Addr_Config_B_o(addr_b), .rdEn_Config_B_o(rd_b),
    .Addr_Config_C_o(addr_c), .rdEn_Config_C_o(rd_c),
    .axonLrnMode_i(lrn_in),
    .nurn_idx_o(nurn_idx), .nurn_vld_o(nurn_vld), .nurn_rdy_i(nurn_rdy),
    .axon_idx_o(axon_idx), .axon_lrn_o(axon_lrn), .axon_vld_o(axon_vld), .axon_rdy_i(axon_rdy)
  );

  bit lrn_mem [0:NN-1][0:NA-1];

  // Port C memory: registered read, output holds until the next enable.
  always @(posedge clk) begin
    int n, a;
    if (rd_c) begin
      n = int'(addr_c[NW+AW-1:AW]);
      a = int'(addr_c[AW-1:0]);
      lrn_in <= (n < NN && a < NA) ? lrn_mem[n][a] : 1'b0;
    end
  end

  int checks = 0, errors = 0;
  int cyc = 0;
  int q_ab[$], q_c[$], q_n[$], q_ax[$], q_done[$];
  int nmode = 0, amode = 0, stall_left = 0;
  bit mon_en = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Ready driver, updated just after each active edge.
  initial begin
    nurn_rdy = 1'b0;
    axon_rdy = 1'b0;
    forever begin
      step();
      case (nmode)
        1: nurn_rdy = 1'($urandom_range(0, 1));
        2: begin
          if (nurn_vld && nurn_idx == 2 && stall_left > 0) begin
            nurn_rdy = 1'b0;
            stall_left--;
          end else begin
            nurn_rdy = 1'b1;
          end
        end
        default: nurn_rdy = 1'b1;
      endcase
      case (amode)
        1: axon_rdy = 1'($urandom_range(0, 1));
        3: axon_rdy = !(axon_vld && nurn_idx == 1 && axon_idx == 1);
        default: axon_rdy = 1'b1;
      endcase
    end
  end

  // Monitor: pops the expected event whenever the DUT presents one.
  initial begin
    bit prev_ns, prev_as;
    int prev_nidx, prev_aval, exp;
    prev_ns = 0;
    prev_as = 0;
    prev_nidx = 0;
    prev_aval = 0;
    forever begin
      @(negedge clk);
      if (!mon_en || rst_i) begin
        prev_ns = 0;
        prev_as = 0;
        continue;
      end
      chk("vld_exclusive", int'(nurn_vld && axon_vld), 0);
      chk("ab_read_while_nurn_vld", int'((rd_a || rd_b) && nurn_vld), 0);
      if (rd_a || rd_b) begin
        chk("ab_together", int'(rd_a && rd_b), 1);
        chk("ab_addr_equal", int'(addr_b), int'(addr_a));
        if (q_ab.size() == 0) chk("ab_read_unexpected", int'(addr_a), -1);
        else begin exp = q_ab.pop_front(); chk("ab_read_addr", int'(addr_a), exp); end
      end
      if (rd_c) begin
        if (q_c.size() == 0) chk("c_read_unexpected", int'(addr_c), -1);
        else begin exp = q_c.pop_front(); chk("c_read_addr", int'(addr_c), exp); end
      end
      if (prev_ns) begin
        chk("nurn_stall_vld", int'(nurn_vld), 1);
        chk("nurn_stall_idx", int'(nurn_idx), prev_nidx);
      end
      if (prev_as) begin
        chk("axon_stall_vld", int'(axon_vld), 1);
        chk("axon_stall_data", (int'(nurn_idx) << 16) | (int'(axon_idx) << 8) | int'(axon_lrn), prev_aval);
      end
      if (nurn_vld && nurn_rdy) begin
        chk("busy_during_nurn", int'(busy_o), 1);
        if (q_n.size() == 0) chk("nurn_unexpected", int'(nurn_idx), -1);
        else begin exp = q_n.pop_front(); chk("nurn_idx", int'(nurn_idx), exp); end
      end
      if (axon_vld && axon_rdy) begin
        if (q_ax.size() == 0) chk("axon_unexpected", int'(axon_idx), -1);
        else begin
          exp = q_ax.pop_front();
          chk("axon_n_a_lrn", (int'(nurn_idx) << 16) | (int'(axon_idx) << 8) | int'(axon_lrn), exp);
        end
      end
      if (done_o) begin
        chk("busy_low_at_done", int'(busy_o), 0);
        if (q_done.size() == 0) chk("done_unexpected", cyc, -1);
        else begin
          exp = q_done.pop_front();
          if (exp >= 0) chk("done_cycle", cyc, exp);
        end
      end
      prev_ns   = nurn_vld && !nurn_rdy;
      prev_nidx = int'(nurn_idx);
      prev_as   = axon_vld && !axon_rdy;
      prev_aval = (int'(nurn_idx) << 16) | (int'(axon_idx) << 8) | int'(axon_lrn);
    end
  end

  task automatic randomize_mem();
    for (int n = 0; n < NN; n++)
      for (int a = 0; a < NA; a++)
        lrn_mem[n][a] = 1'($urandom_range(0, 1));
  endtask

  // Reference: a scan is the neuron list, optionally each neuron's axon list, then one done.
  task automatic start_scan(input bit en, input int lat);
    for (int n = 0; n < NN; n++) begin
      q_ab.push_back(n);
      q_n.push_back(n);
      if (en) begin
        for (int a = 0; a < NA; a++) begin
          q_c.push_back(n * 256 + a);
          q_ax.push_back((n << 16) | (a << 8) | int'(lrn_mem[n][a]));
        end
      end
    end
    q_done.push_back(lat < 0 ? -1 : cyc + 1 + lat);
    axon_scan_en_i = en;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    axon_scan_en_i = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (done_o) begin seen = 1; break; end
    end
    if (!seen) chk("done_timeout", 0, 1);
  endtask

  task automatic settle();
    repeat (2) step();
    chk("queues_drained", q_ab.size() + q_c.size() + q_n.size() + q_ax.size() + q_done.size(), 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_done"}, int'(done_o), 0);
    chk({tag, "_rden"}, int'({rd_a, rd_b, rd_c}), 0);
    chk({tag, "_addr_ab"}, int'({addr_a, addr_b}), 0);
    chk({tag, "_addr_c"}, int'(addr_c), 0);
    chk({tag, "_idx"}, int'({nurn_idx, axon_idx}), 0);
    chk({tag, "_vld_lrn"}, int'({nurn_vld, axon_vld, axon_lrn}), 0);
  endtask

  initial begin
    bit found;
    rst_i = 1'b1;
    start_i = 1'b0;
    axon_scan_en_i = 1'b0;
    randomize_mem();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    step();
    rst_i = 1'b0;
    mon_en = 1;
    step();

    // neuron-only scan, ready high
    start_scan(0, NN * 3);
    wait_done();
    settle();

    // axon scan, ready high
    randomize_mem();
    start_scan(1, NN * (3 + 2 * NA));
    wait_done();
    settle();

    // neuron 2 stalled for five cycles
    nmode = 2;
    stall_left = 5;
    start_scan(0, NN * 3 + 5);
    wait_done();
    settle();
    chk("stall_consumed", stall_left, 0);
    nmode = 0;

    // random ready on both handshakes
    nmode = 1;
    amode = 1;
    for (int r = 0; r < 3; r++) begin
      randomize_mem();
      start_scan(1, -1);
      wait_done();
      settle();
    end
    nmode = 0;
    amode = 0;
    step();

    // start mid-scan and in the done cycle are ignored
    start_scan(0, NN * 3);
    repeat (4) step();
    axon_scan_en_i = 1'b1;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    wait_done();
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("idle_after_done_start", int'(busy_o), 0);
    settle();
    randomize_mem();
    start_scan(1, NN * (3 + 2 * NA));
    wait_done();
    settle();

    // reset in AOUT at neuron 1 axon 1, with start asserted alongside
    randomize_mem();
    lrn_mem[1][1] = 1'b1;
    amode = 3;
    start_scan(1, -1);
    found = 0;
    for (int i = 0; i < 500; i++) begin
      if (axon_vld && nurn_idx == 1 && axon_idx == 1) begin found = 1; break; end
      step();
    end
    chk("reached_n1_a1", int'(found), 1);
    rst_i = 1'b1;
    start_i = 1'b1;
    q_ab.delete();
    q_c.delete();
    q_n.delete();
    q_ax.delete();
    q_done.delete();
    step();
    rst_i = 1'b0;
    start_i = 1'b0;
    amode = 0;
    @(negedge clk);
    check_zero("midscan_reset");
    step();
    repeat (3) step();
    chk("idle_after_reset", int'(busy_o), 0);
    start_scan(1, NN * (3 + 2 * NA));
    wait_done();
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
